// File: rtl/serial_word_rx.sv
// serial_word_rx: serial-to-parallel word receiver.
// Accepts one strobed bit per clock and assembles WIDTH-bit frames MSB-first or
// LSB-first, with the direction chosen at the frame-start bit. A completed word
// goes into a single-entry holding register with a valid/ready handshake. A
// sticky overrun flag records words dropped because the holding register was
// still full.
// Optional feature macro: RX_PARITY_EN adds a trailing even-parity bit per frame
// and drives PERR. Without it, PERR is tied low.
module serial_word_rx #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SI,
  input  logic             SI_STB,
  input  logic             SI_FRM,
  input  logic             DIR,
  output logic [WIDTH-1:0] PDATA,
  output logic             PVALID,
  input  logic             PREADY,
  output logic             BUSY,
  output logic             OVR,
  output logic             PERR
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef RX_PARITY_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] sr, sr_d;
  logic             dir_q, dir_d;
  logic             done;
  logic [WIDTH-1:0] word;
`ifdef RX_PARITY_EN
  logic             par_err;
  logic             perr_q;
`endif

  // DIR=0 shifts left with the new bit entering bit 0; DIR=1 shifts right with
  // the new bit entering the top bit. After WIDTH shifts the frame is aligned.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic bit_in,
                                                input logic lsb_first);
    if (lsb_first) return {bit_in, cur[WIDTH-1:1]};
    else           return {cur[WIDTH-2:0], bit_in};
  endfunction

  // Next-state logic. A frame-start strobe restarts from any state and
  // silently discards a partial frame.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sr_d    = sr;
    dir_d   = dir_q;
    done    = 1'b0;
    word    = sr;
`ifdef RX_PARITY_EN
    par_err = 1'b0;
`endif
    if (SI_STB) begin
      if (SI_FRM) begin
        state_d = SHIFT;
        dir_d   = DIR;
        sr_d    = shift_in(sr, SI, DIR);
        cnt_d   = CNT_W'(1);
      end else begin
        case (state)
          SHIFT: begin
            sr_d  = shift_in(sr, SI, dir_q);
            cnt_d = cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
              state_d = PAR;
`else
              state_d = IDLE;
              done    = 1'b1;
              word    = sr_d;
`endif
            end
          end
`ifdef RX_PARITY_EN
          PAR: begin
            state_d = IDLE;
            done    = 1'b1;
            word    = sr;
            par_err = ^{sr, SI};
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // ---- stage boundary: frame assembly registers ----
  // Shift register, bit count, direction latch and FSM state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sr    <= sr_d;
      dir_q <= dir_d;
    end
  end

  // ---- stage boundary: holding register ----
  // Handshaked output. A completed word is loaded only if the slot is empty or
  // is being drained on this same edge; otherwise it is dropped and the
  // overrun flag is set.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PDATA  <= '0;
      PVALID <= 1'b0;
      OVR    <= 1'b0;
    end else if (done) begin
      if (!PVALID || PREADY) begin
        PDATA  <= word;
        PVALID <= 1'b1;
      end else begin
        OVR <= 1'b1;
      end
    end else if (PVALID && PREADY) begin
      PVALID <= 1'b0;
    end
  end

`ifdef RX_PARITY_EN
  // The parity error flag travels with the word in the holding register.
  always_ff @(posedge CLK) begin
    if (RESET)                          perr_q <= 1'b0;
    else if (done && (!PVALID || PREADY)) perr_q <= par_err;
  end
  assign PERR = perr_q;
`else
  assign PERR = 1'b0;
`endif

  assign BUSY = (state != IDLE);

endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of data bits per frame (legal range 4..32).
REQ-002 SHALL have port CLK  input  1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1: synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 SHALL have port SI  input  1: serial data bit, valid when SI_STB=1.
REQ-005 SHALL have port SI_STB  input  1: bit strobe; one bit accepted per CLK edge with SI_STB=1.
REQ-006 SHALL have port SI_FRM  input  1: frame start; meaningful only with SI_STB=1, marks that bit as data bit 0 of a frame.
REQ-007 SHALL have port DIR  input  1: 0 = MSB first (left shift, new bit into bit 0); 1 = LSB first (right shift, new bit into bit WIDTH-1).
REQ-008 SHALL have port PDATA  output  WIDTH: received word in the holding register.
REQ-009 SHALL have port PVALID  output  1: holding register full.
REQ-010 SHALL have port PREADY  input  1: consumer accepts PDATA on an edge where PVALID=1 and PREADY=1.
REQ-011 SHALL have port BUSY  output  1: frame in progress (state not IDLE).
REQ-012 SHALL have port OVR  output  1: sticky overrun flag.
REQ-013 SHALL have port PERR  output  1: parity error for the word in the holding register.

Function
REQ-014 SHALL implement the states IDLE, SHIFT and, with RX_PARITY_EN, PAR.
REQ-015 In IDLE, SHALL ignore SI_STB=1 while SI_FRM=0.
REQ-016 In IDLE, on SI_STB=1 and SI_FRM=1, SHALL latch DIR for the frame, shift in SI, set the bit count to 1, and go to SHIFT.
REQ-017 In SHIFT, on SI_STB=1 and SI_FRM=0, SHALL shift SI in the latched direction and increment the bit count.
REQ-018 The bit count SHALL use ceil(log2(WIDTH+1)) bits and SHALL never wrap.
REQ-019 In SHIFT with SI_STB=0, SHALL hold all state; gaps between bits are unlimited.
REQ-020 On SI_STB=1 with SI_FRM=1 in SHIFT or PAR, SHALL discard the partial frame and restart per REQ-016 in the same edge, with no OVR and no PVALID.
REQ-021 When the strobe carrying data bit WIDTH-1 is accepted, SHALL complete the word: go to IDLE without RX_PARITY_EN, or to PAR with it.
REQ-022 On word completion, SHALL load the holding register and set PVALID=1 on the following edge, giving latency 1 CLK from the final-bit strobe.
REQ-023 On an edge with PVALID=1 and PREADY=1 and no completion, SHALL clear PVALID.
REQ-024 On completion with PVALID=1 and PREADY=1 on the same edge, SHALL load the new word and keep PVALID=1, with no overrun.
REQ-025 On completion with PVALID=1 and PREADY=0, SHALL drop the new word, leave PDATA unchanged, and set OVR=1.
REQ-026 OVR SHALL clear only on RESET.
REQ-027 PDATA SHALL be stable while PVALID=1 and PREADY=0.
REQ-028 BUSY SHALL be 1 in SHIFT and PAR, and 0 in IDLE.

Reset
REQ-029 While RESET=1, SHALL force state IDLE, bit count 0, shift register 0, PDATA 0, PVALID 0, OVR 0 and PERR 0.
REQ-030 RESET SHALL take priority over all inputs; a frame in progress SHALL be discarded without setting OVR.
REQ-031 The first edge after RESET deasserts SHALL accept SI_FRM normally.

Configuration
REQ-032 Macro RX_PARITY_EN SHALL control parity support.
REQ-033 With RX_PARITY_EN defined, the next SI_STB=1 with SI_FRM=0 in PAR SHALL be taken as the parity bit, and the word SHALL complete on that edge.
REQ-034 With RX_PARITY_EN defined, PERR SHALL be loaded with PDATA and SHALL be 1 when the XOR of the WIDTH data bits and the parity bit is 1 (even parity).
REQ-035 With RX_PARITY_EN defined, a word with PERR=1 SHALL still be delivered.
REQ-036 Without RX_PARITY_EN, the PAR state SHALL be absent, PERR SHALL be constant 0, and the port SHALL remain present.

Verification
REQ-037 WIDTH=32, DIR=0, shift 0xDEADBEEF MSB-first with 1-cycle gaps, PREADY=1 -> PVALID=1 for 1 cycle, 1 CLK after the last strobe, PDATA=0xDEADBEEF, OVR=0.
REQ-038 DIR=1, send bits LSB-first for 0x12345678 -> PDATA=0x12345678; DIR toggled mid-frame -> no effect.
REQ-039 PREADY=0, send 2 frames 0x00000001 then 0xFFFFFFFF -> PDATA=0x00000001, PVALID=1, OVR=1; then PREADY=1 -> PVALID=0, OVR stays 1.
REQ-040 Send 10 bits, then SI_FRM restarts frame 0xA5A5A5A5 -> PDATA=0xA5A5A5A5 only, OVR=0; RESET mid-frame -> all outputs 0, no PVALID.
REQ-041 RX_PARITY_EN defined, 0x00000007 with parity 1 -> PERR=0; same data with parity 0 -> PERR=1 and PVALID=1.
REQ-042 Back-to-back frames with PREADY=1 held on the completion edge -> PVALID stays 1 and PDATA updates, OVR=0.
